// File: rtl/dac_test_pkg.sv
// Shared types and constants for the DAC test firmware clock divider and its period meter.
package dac_test_pkg;

    localparam int unsigned DIV_CNT_W = 27;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2,
        STALL   = 2'd3
    } meter_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous level, with a rising-edge pulse on the synchronised level.
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_in,
    input  logic d,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            s_d    <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;

endmodule

// File: rtl/div_clk_period_meter.sv
// Measures period and high time of an asynchronous divided clock in clk cycles, with stall detection.
module div_clk_period_meter
    import dac_test_pkg::*;
#(
    parameter int unsigned CNT_W          = DIV_CNT_W,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 2**27 - 1
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             en,
    input  logic             div_clk_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             period_valid,
    output logic             locked,
    output logic             stalled
);

    meter_state_t     state;
    meter_state_t     state_next;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic             s;
    logic             rise;
    logic             timeout_c;
    logic             report_c;
    logic             cnt_clr_c;
    logic             cnt_load_c;
    logic             cnt_run_c;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_in(rst_in),
        .d     (div_clk_in),
        .s     (s),
        .rise  (rise)
    );

    assign timeout_c = (per_cnt == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_next;
    end

    // Disable overrides everything; a rise beats a coincident timeout.
    always_comb begin
        state_next = state;
        if (!en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (rise) state_next = ARMED;
                ARMED:   if (rise) state_next = MEASURE;
                         else if (timeout_c) state_next = STALL;
                MEASURE: if (timeout_c && !rise) state_next = STALL;
                STALL:   if (rise) state_next = ARMED;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        report_c   = 1'b0;
        cnt_clr_c  = 1'b0;
        cnt_load_c = 1'b0;
        cnt_run_c  = 1'b0;
        if (!en) begin
            cnt_clr_c = 1'b1;
        end else if (rise) begin
            cnt_load_c = 1'b1;
            report_c   = (state == ARMED) || (state == MEASURE);
        end else begin
            case (state)
                IDLE:          cnt_clr_c = 1'b1;
                ARMED, MEASURE: cnt_run_c = !timeout_c;
                default:       cnt_run_c = 1'b0;
            endcase
        end
    end

    // Counters restart at 1 on a rise so the edge cycle belongs to the new period.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (cnt_clr_c) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (cnt_load_c) begin
            per_cnt <= CNT_W'(1);
            hi_cnt  <= CNT_W'(s);
        end else if (cnt_run_c) begin
            per_cnt <= per_cnt + CNT_W'(1);
            if (s) hi_cnt <= hi_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            period_out   <= '0;
            high_out     <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            stalled      <= 1'b0;
        end else begin
            period_valid <= report_c;
            stalled      <= (state_next == STALL);
            if (report_c) begin
                period_out <= per_cnt;
                high_out   <= hi_cnt;
            end
            if (!en || state_next == STALL) locked <= 1'b0;
            else if (report_c)              locked <= 1'b1;
        end
    end

endmodule

// File: tb/tb_div_clk_period_meter.sv
// Directed bench for div_clk_period_meter with hand-computed periods, timeout and priority cases.
module tb_div_clk_period_meter;
    import dac_test_pkg::*;

    localparam int unsigned CNT_W = 27;

    logic             clk = 1'b0;
    logic             rst_in;
    logic             en;
    logic             div_clk_in;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             period_valid;
    logic             locked;
    logic             stalled;

    int          errors = 0;
    int          checks = 0;
    int          nrep   = 0;
    logic [31:0] exp_per = '0;
    logic [31:0] exp_hi  = '0;

    div_clk_period_meter #(
        .CNT_W         (CNT_W),
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk         (clk),
        .rst_in      (rst_in),
        .en          (en),
        .div_clk_in  (div_clk_in),
        .period_out  (period_out),
        .high_out    (high_out),
        .period_valid(period_valid),
        .locked      (locked),
        .stalled     (stalled)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock; any report seen is checked against the current expectation.
    task automatic tick();
        @(posedge clk);
        #1;
        if (period_valid) begin
            nrep++;
            check("period_out", 32'(period_out), exp_per);
            check("high_out", 32'(high_out), exp_hi);
        end
    endtask

    task automatic gen(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            div_clk_in = 1'b1;
            repeat (hi) tick();
            div_clk_in = 1'b0;
            repeat (lo) tick();
        end
    endtask

    task automatic run(input int hi, input int lo, input int n, input int exp_n);
        nrep    = 0;
        exp_per = 32'(hi + lo);
        exp_hi  = 32'(hi);
        gen(hi, lo, n);
        check("report_count", 32'(nrep), 32'(exp_n));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_period_out"}, 32'(period_out), 32'd0);
        check({tag, "_high_out"}, 32'(high_out), 32'd0);
        check({tag, "_valid"}, 32'(period_valid), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_stalled"}, 32'(stalled), 32'd0);
    endtask

    initial begin
        rst_in     = 1'b0;
        en         = 1'b0;
        div_clk_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_in = 1'b1;
        nrep   = 0;
        repeat (5) tick();
        check("idle_reports", 32'(nrep), 32'd0);
        check("idle_state", 32'(int'(dut.state)), 32'(int'(IDLE)));
        check_zero("idle");

        // Steady 50% duty, period 10.
        en = 1'b1;
        repeat (2) tick();
        run(5, 5, 6, 5);
        check("steady_locked", 32'(locked), 32'd1);
        check("steady_stalled", 32'(stalled), 32'd0);

        // Two more periods seamlessly, then hold low until the 64-cycle timeout.
        run(5, 5, 2, 2);
        nrep = 0;
        repeat (56) tick();
        check("pre_to_stalled", 32'(stalled), 32'd0);
        check("pre_to_locked", 32'(locked), 32'd1);
        tick();
        check("to_stalled", 32'(stalled), 32'd1);
        check("to_locked", 32'(locked), 32'd0);
        check("to_period_hold", 32'(period_out), 32'd10);
        check("to_high_hold", 32'(high_out), 32'd5);
        repeat (20) tick();
        check("stall_persist", 32'(stalled), 32'd1);
        check("stall_reports", 32'(nrep), 32'd0);

        // Resume: first report only at the second new rise.
        run(5, 5, 3, 2);
        check("resume_stalled", 32'(stalled), 32'd0);
        check("resume_locked", 32'(locked), 32'd1);

        // en drops exactly on the cycle the synchronised rise is seen.
        div_clk_in = 1'b1;
        tick();
        tick();
        en   = 1'b0;
        nrep = 0;
        repeat (3) tick();
        check("prio_reports", 32'(nrep), 32'd0);
        check("prio_locked", 32'(locked), 32'd0);
        check("prio_stalled", 32'(stalled), 32'd0);
        check("prio_state", 32'(int'(dut.state)), 32'(int'(IDLE)));
        check("prio_period_hold", 32'(period_out), 32'd10);
        div_clk_in = 1'b0;
        repeat (5) tick();
        en = 1'b1;
        tick();

        // Asymmetric duty: high 3, low 9.
        run(3, 9, 4, 3);
        check("asym_locked", 32'(locked), 32'd1);
        check("asym_high_out", 32'(high_out), 32'd3);

        // Asynchronous reset in the middle of a period.
        div_clk_in = 1'b1;
        repeat (5) tick();
        #2;
        rst_in = 1'b0;
        #1;
        check_zero("async_rst");
        repeat (2) @(posedge clk);
        #1;
        div_clk_in = 1'b0;
        rst_in     = 1'b1;
        nrep       = 0;
        repeat (3) tick();
        check("post_rst_reports", 32'(nrep), 32'd0);
        run(4, 6, 3, 2);
        check("relock_locked", 32'(locked), 32'd1);
        check("relock_period", 32'(period_out), 32'd10);
        check("relock_high", 32'(high_out), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
